// File: rtl/network_and.sv
// Three-neuron spiking network: neurons 1 and 2 integrate asynchronous spike inputs,
// neuron 3 combines their spikes so that it behaves as an AND of the two layer-1 outputs.
module network_and (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       w1,
    input  logic       w2,
    input  logic       w3,
    input  logic [7:0] th1,
    input  logic [7:0] th2,
    input  logic [7:0] th3,
    input  logic       p_in_1,
    input  logic       n_in_1,
    input  logic       p_in_2,
    input  logic       n_in_2,
    output logic       p_out_3,
    output logic       n_out_3,
    output logic       o1,
    output logic       o2
);

    typedef struct packed {
        logic              pos;
        logic              neg;
        logic signed [9:0] v;
    } nstep_t;

    // Saturating integrate-and-fire step; np/nn are event counts (0..2) this cycle.
    function automatic nstep_t neuron_step(
        input logic signed [9:0] v,
        input logic [1:0]        np,
        input logic [1:0]        nn,
        input logic              w,
        input logic [7:0]        th
    );
        nstep_t             r;
        logic signed [11:0] delta;
        logic signed [11:0] sum;
        logic signed [9:0]  vs;
        logic signed [10:0] thp;
        logic signed [10:0] vx;
        if (w) begin
            delta = $signed({10'd0, np}) - $signed({10'd0, nn});
        end else begin
            delta = 12'sd0;
        end
        sum = $signed({{2{v[9]}}, v}) + delta;
        if (sum > 12'sd511) begin
            vs = 10'sd511;
        end else if (sum < -12'sd512) begin
            vs = -10'sd512;
        end else begin
            vs = sum[9:0];
        end
        thp   = $signed({3'd0, th});
        vx    = $signed({vs[9], vs});
        r.pos = 1'b0;
        r.neg = 1'b0;
        r.v   = vs;
        if ((th != 8'd0) && (vx >= thp)) begin
            r.pos = 1'b1;
            r.v   = 10'sd0;
        end else if ((th != 8'd0) && (vx <= -thp)) begin
            r.neg = 1'b1;
            r.v   = 10'sd0;
        end else begin
            r.pos = 1'b0;
        end
        return r;
    endfunction

    // Toggle flops: one per spike input, clocked by the spike itself.
    logic tog_p1_q, tog_n1_q, tog_p2_q, tog_n2_q;
    logic tog_p1_d, tog_n1_d, tog_p2_d, tog_n2_d;

    // Next toggle values are simply the inversions.
    always_comb begin
        tog_p1_d = ~tog_p1_q;
        tog_n1_d = ~tog_n1_q;
        tog_p2_d = ~tog_p2_q;
        tog_n2_d = ~tog_n2_q;
    end

    // Capture of p_in_1 edges.
    always_ff @(posedge p_in_1 or negedge rst_n) begin
        if (!rst_n) tog_p1_q <= 1'b0;
        else        tog_p1_q <= tog_p1_d;
    end

    // Capture of n_in_1 edges.
    always_ff @(posedge n_in_1 or negedge rst_n) begin
        if (!rst_n) tog_n1_q <= 1'b0;
        else        tog_n1_q <= tog_n1_d;
    end

    // Capture of p_in_2 edges.
    always_ff @(posedge p_in_2 or negedge rst_n) begin
        if (!rst_n) tog_p2_q <= 1'b0;
        else        tog_p2_q <= tog_p2_d;
    end

    // Capture of n_in_2 edges.
    always_ff @(posedge n_in_2 or negedge rst_n) begin
        if (!rst_n) tog_n2_q <= 1'b0;
        else        tog_n2_q <= tog_n2_d;
    end

    // Bit order everywhere below: {n_in_2, p_in_2, n_in_1, p_in_1}.
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] sync1_d, sync2_d, prev_d;
    logic [3:0] ev_s;

    logic signed [9:0] v1_q, v2_q, v3_q;
    logic signed [9:0] v1_d, v2_d, v3_d;
    logic              pos1_q, neg1_q, pos2_q, neg2_q, pos3_q, neg3_q;
    logic              pos1_d, neg1_d, pos2_d, neg2_d, pos3_d, neg3_d;
    nstep_t            s1_s, s2_s, s3_s;

    // Synchronizer chain and edge detection; reset-to-zero avoids a spurious event on release.
    always_comb begin
        sync1_d = {tog_n2_q, tog_p2_q, tog_n1_q, tog_p1_q};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        ev_s    = sync2_q ^ prev_q;
    end

    // Neuron updates; neuron 3 consumes the registered layer-1 spikes directly.
    always_comb begin
        s1_s   = neuron_step(v1_q, {1'b0, ev_s[0]}, {1'b0, ev_s[1]}, w1, th1);
        s2_s   = neuron_step(v2_q, {1'b0, ev_s[2]}, {1'b0, ev_s[3]}, w2, th2);
        s3_s   = neuron_step(v3_q, {1'b0, pos1_q} + {1'b0, pos2_q},
                                   {1'b0, neg1_q} + {1'b0, neg2_q}, w3, th3);
        v1_d   = s1_s.v;
        pos1_d = s1_s.pos;
        neg1_d = s1_s.neg;
        v2_d   = s2_s.v;
        pos2_d = s2_s.pos;
        neg2_d = s2_s.neg;
        v3_d   = s3_s.v;
        pos3_d = s3_s.pos;
        neg3_d = s3_s.neg;
    end

    // Clock-domain state: synchronizers, potentials and spike registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            prev_q  <= 4'd0;
            v1_q    <= 10'sd0;
            v2_q    <= 10'sd0;
            v3_q    <= 10'sd0;
            pos1_q  <= 1'b0;
            neg1_q  <= 1'b0;
            pos2_q  <= 1'b0;
            neg2_q  <= 1'b0;
            pos3_q  <= 1'b0;
            neg3_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            pos1_q  <= pos1_d;
            neg1_q  <= neg1_d;
            pos2_q  <= pos2_d;
            neg2_q  <= neg2_d;
            pos3_q  <= pos3_d;
            neg3_q  <= neg3_d;
        end
    end

    assign o1      = pos1_q;
    assign o2      = pos2_q;
    assign p_out_3 = pos3_q;
    assign n_out_3 = neg3_q;

endmodule

// File: tb/tb_network_and.sv
// Directed bench for network_and: counts output pulses per scenario and compares
// them with hand-derived expectations.
module tb_network_and;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w1 = 1'b1, w2 = 1'b1, w3 = 1'b1;
    logic [7:0] th1 = 8'd4, th2 = 8'd4, th3 = 8'd2;
    logic       p_in_1 = 1'b0, n_in_1 = 1'b0, p_in_2 = 1'b0, n_in_2 = 1'b0;
    logic       p_out_3, n_out_3, o1, o2;

    int checks = 0;
    int errors = 0;
    int c_o1 = 0, c_o2 = 0, c_p3 = 0, c_n3 = 0;
    int b_o1, b_o2, b_p3, b_n3;

    network_and dut (
        .clk(clk), .rst_n(rst_n),
        .w1(w1), .w2(w2), .w3(w3),
        .th1(th1), .th2(th2), .th3(th3),
        .p_in_1(p_in_1), .n_in_1(n_in_1), .p_in_2(p_in_2), .n_in_2(n_in_2),
        .p_out_3(p_out_3), .n_out_3(n_out_3), .o1(o1), .o2(o2)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (o1)      c_o1 <= c_o1 + 1;
        if (o2)      c_o2 <= c_o2 + 1;
        if (p_out_3) c_p3 <= c_p3 + 1;
        if (n_out_3) c_n3 <= c_n3 + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #23;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        b_o1 = c_o1; b_o2 = c_o2; b_p3 = c_p3; b_n3 = c_n3;
    endtask

    // m bits: {n_in_2, p_in_2, n_in_1, p_in_1}; n spikes 11 ns apart.
    task automatic spikes(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            {n_in_2, p_in_2, n_in_1, p_in_1} = m;
            #2;
            {n_in_2, p_in_2, n_in_1, p_in_1} = 4'b0000;
            #9;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic check_counts(input string tag, input int e1, input int e2,
                                input int ep, input int en);
        check_eq({tag, "_o1"}, c_o1 - b_o1, e1);
        check_eq({tag, "_o2"}, c_o2 - b_o2, e2);
        check_eq({tag, "_p3"}, c_p3 - b_p3, ep);
        check_eq({tag, "_n3"}, c_n3 - b_n3, en);
    endtask

    initial begin
        #17;
        check_eq("rst_o1", int'(o1), 0);
        check_eq("rst_o2", int'(o2), 0);
        check_eq("rst_p3", int'(p_out_3), 0);
        check_eq("rst_n3", int'(n_out_3), 0);

        do_reset();
        check_counts("release", 0, 0, 0, 0);

        do_reset();
        spikes(4'b1010, 4);
        check_counts("nn", 0, 0, 0, 1);

        do_reset();
        spikes(4'b0110, 4);
        check_counts("np", 0, 1, 0, 0);

        do_reset();
        spikes(4'b1001, 4);
        check_counts("pn", 1, 0, 0, 0);

        do_reset();
        spikes(4'b0101, 4);
        check_counts("pp", 1, 1, 1, 0);

        // Disabled threshold: 20 spikes never fire.
        th1 = 8'd0;
        do_reset();
        spikes(4'b0001, 20);
        check_eq("th0_o1", c_o1 - b_o1, 0);

        // Zero weight.
        th1 = 8'd1; w1 = 1'b0;
        do_reset();
        spikes(4'b0001, 3);
        check_eq("w0_o1", c_o1 - b_o1, 0);

        // Threshold 1 fires on a single spike, within a bounded number of cycles.
        w1 = 1'b1;
        do_reset();
        begin
            int lat;
            lat = -1;
            #1;
            p_in_1 = 1'b1; #2; p_in_1 = 1'b0;
            for (int k = 1; k <= 6 && lat < 0; k++) begin
                @(negedge clk);
                if (o1) lat = k;
            end
            check_eq("lat_found", int'(lat > 0), 1);
            repeat (6) @(negedge clk);
            check_eq("th1_o1", c_o1 - b_o1, 1);
        end

        // Simultaneous p and n cancel.
        do_reset();
        spikes(4'b0011, 3);
        check_eq("cancel_o1", c_o1 - b_o1, 0);

        // Reset mid-integration discards potential.
        th1 = 8'd4;
        do_reset();
        spikes(4'b0001, 3);
        do_reset();
        spikes(4'b0001, 1);
        check_eq("rstmid_o1", c_o1 - b_o1, 0);
        spikes(4'b0001, 3);
        check_eq("rstmid_refire", c_o1 - b_o1, 1);

        // Saturation at +511: 600 spikes with firing off, then one n spike with th1=255.
        th1 = 8'd0;
        do_reset();
        spikes(4'b0001, 600);
        th1 = 8'd255;
        @(negedge clk);
        spikes(4'b0010, 1);
        check_eq("sat_o1", c_o1 - b_o1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
